// File: rtl/ucode_loader_pkg.sv
// Shared constants for the microcode loader: default sizes, frame header and FSM encoding.
// ST_CKSUM exists only when UCODE_LOADER_CKSUM_EN is defined.
package ucode_loader_pkg;

    localparam int UCODE_WORD_SIZE = 32;
    localparam int UCODE_ADDR_SIZE = 5;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    typedef logic [2:0] ldr_state_t;

    localparam ldr_state_t ST_IDLE  = 3'd0;
    localparam ldr_state_t ST_COUNT = 3'd1;
    localparam ldr_state_t ST_ADDR  = 3'd2;
    localparam ldr_state_t ST_DATA  = 3'd3;
`ifdef UCODE_LOADER_CKSUM_EN
    localparam ldr_state_t ST_CKSUM = 3'd4;
`endif
    localparam ldr_state_t ST_DONE  = 3'd5;

    function automatic int bytes_per_word(input int word_bits);
        return (word_bits + 7) / 8;
    endfunction

endpackage

// File: rtl/ucode_word_asm.sv
// Little-endian byte-to-word assembler: shifts bytes in from the top, pulses word_done
// the cycle after the last byte of a word, with the word held stable in 'word'.
module ucode_word_asm
    import ucode_loader_pkg::*;
#(
    parameter int WORD_SIZE = UCODE_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 byte_en,
    input  logic [7:0]           byte_data,
    output logic                 last_byte,
    output logic                 word_done,
    output logic [WORD_SIZE-1:0] word
);

    localparam int BPW = bytes_per_word(WORD_SIZE);
    localparam int SW  = BPW * 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] cnt;
    logic [SW-1:0] shreg;
    logic [SW-1:0] shnext;

    // First byte received ends up in bits [7:0] once BPW bytes have been shifted in.
    assign shnext    = (shreg >> 8) | (SW'(byte_data) << (SW - 8));
    assign last_byte = (cnt == CW'(BPW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            shreg     <= '0;
            word      <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (clear) begin
                cnt   <= '0;
                shreg <= '0;
            end else if (byte_en) begin
                shreg <= shnext;
                if (last_byte) begin
                    cnt       <= '0;
                    word      <= shnext[WORD_SIZE-1:0];
                    word_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ucode_loader.sv
// Byte-stream microcode loader: parses A5/N/S/words[/checksum] frames into control-store writes.
// Optional checksum byte and sticky err flag are enabled by defining UCODE_LOADER_CKSUM_EN.
module ucode_loader
    import ucode_loader_pkg::*;
#(
    parameter int WORD_SIZE = UCODE_WORD_SIZE,
    parameter int ADDR_SIZE = UCODE_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

`ifdef UCODE_LOADER_CKSUM_EN
    localparam ldr_state_t ST_AFTER_DATA = ST_CKSUM;
`else
    localparam ldr_state_t ST_AFTER_DATA = ST_DONE;
`endif

    ldr_state_t           state;
    logic [7:0]           n_cnt;
    logic [ADDR_SIZE-1:0] s_addr;
    logic [7:0]           word_idx;
    logic                 accept;
    logic                 data_en;
    logic                 last_byte;
    logic                 last_word;

    assign in_ready  = (state != ST_DONE);
    assign accept    = in_valid && in_ready;
    assign data_en   = accept && (state == ST_DATA);
    assign last_word = (word_idx == (n_cnt - 8'd1));
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    ucode_word_asm #(
        .WORD_SIZE (WORD_SIZE)
    ) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == ST_IDLE),
        .byte_en   (data_en),
        .byte_data (in_data),
        .last_byte (last_byte),
        .word_done (wr_en),
        .word      (wr_data)
    );

`ifdef UCODE_LOADER_CKSUM_EN
    logic [7:0] cksum;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            n_cnt    <= '0;
            s_addr   <= '0;
            word_idx <= '0;
            wr_addr  <= '0;
`ifdef UCODE_LOADER_CKSUM_EN
            cksum    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (in_data == FRAME_HEADER)) begin
                        state    <= ST_COUNT;
                        word_idx <= '0;
`ifdef UCODE_LOADER_CKSUM_EN
                        cksum    <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                ST_COUNT: begin
                    if (accept) begin
                        n_cnt <= in_data;
`ifdef UCODE_LOADER_CKSUM_EN
                        cksum <= in_data;
`endif
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (accept) begin
                        s_addr <= ADDR_SIZE'(in_data);
`ifdef UCODE_LOADER_CKSUM_EN
                        cksum  <= cksum ^ in_data;
`endif
                        state  <= (n_cnt != 8'd0) ? ST_DATA : ST_AFTER_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
`ifdef UCODE_LOADER_CKSUM_EN
                        cksum <= cksum ^ in_data;
`endif
                        // Address is registered alongside the assembler's word_done pulse.
                        if (last_byte) begin
                            wr_addr  <= s_addr + ADDR_SIZE'(word_idx);
                            word_idx <= word_idx + 8'd1;
                            if (last_word)
                                state <= ST_AFTER_DATA;
                        end
                    end
                end
`ifdef UCODE_LOADER_CKSUM_EN
                ST_CKSUM: begin
                    if (accept) begin
                        if (in_data != cksum)
                            err_q <= 1'b1;
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
